// File: rtl/conv_pkg.sv
// Shared convolution constants and the packed 3x3 window layout.
// Element (r,c) of a window: r=0 oldest row, c=0 leftmost column, top-left in the MSBs.
package conv_pkg;

   localparam int KERNEL = 3;
   localparam int DATA_W = 8;
   localparam int WIN_W  = KERNEL * KERNEL * DATA_W;

   function automatic int win_lsb(input int r, input int c, input int dw);
      return dw * (KERNEL * KERNEL - 1 - (KERNEL * r + c));
   endfunction

endpackage

// File: rtl/conv_window_gen_if.sv
// Pixel-in / window-out stream bundle; master is the window generator, slave its environment.
// Both streams use valid/ready; a transfer happens when valid and ready are high at a clock edge.
interface conv_window_gen_if #(
   parameter int DATA_W = 8
);

   logic                                         pix_valid;
   logic                                         pix_ready;
   logic [DATA_W-1:0]                            pix_data;
   logic                                         win_valid;
   logic                                         win_ready;
   logic [conv_pkg::KERNEL*conv_pkg::KERNEL*DATA_W-1:0] window;
   logic                                         win_last;

   modport master (
      input  pix_valid, pix_data, win_ready,
      output pix_ready, win_valid, window, win_last
   );

   modport slave (
      output pix_valid, pix_data, win_ready,
      input  pix_ready, win_valid, window, win_last
   );

endinterface

// File: rtl/line_buffer.sv
// Enable-gated delay line of DEPTH samples, circular RAM with a single pointer, 0-cycle read.
// Holds completely while en is low, so stalls upstream simply pause it.
module line_buffer #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 28
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic [DATA_W-1:0] din,
   output logic [DATA_W-1:0] dout
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [DATA_W-1:0] mem [DEPTH];
   logic [PW-1:0]     ptr;

   // The slot about to be overwritten holds the sample written DEPTH enables ago.
   assign dout = mem[ptr];

   always_ff @(posedge clk) begin
      if (en) begin
         mem[ptr] <= din;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr <= '0;
      end else if (en) begin
         ptr <= (ptr == PW'(DEPTH - 1)) ? '0 : ptr + 1'b1;
      end
   end

endmodule

// File: rtl/conv_window_gen.sv
// Raster pixel stream to valid 3x3 windows; window appears 1 cycle after its last pixel.
// Single output register: pix_ready = !win_valid || win_ready, so a stalled window freezes the stream.
module conv_window_gen
   import conv_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int IMG_W  = 28,
   parameter int IMG_H  = 28
) (
   input  logic                  clk,
   input  logic                  rst,
   conv_window_gen_if.master     io
);

   localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
   localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
   localparam int WW = KERNEL * KERNEL * DATA_W;

   logic [CW-1:0]     col;
   logic [RW-1:0]     row;
   logic              accept;
   logic              last_col;
   logic              last_row;
   logic              produce;
   logic [DATA_W-1:0] row1_pix;
   logic [DATA_W-1:0] row2_pix;
   logic [DATA_W-1:0] arr      [KERNEL][KERNEL];
   logic [DATA_W-1:0] next_arr [KERNEL][KERNEL];
   logic [WW-1:0]     next_win;
   logic              win_valid_q;
   logic              win_last_q;
   logic [WW-1:0]     window_q;

   assign io.pix_ready = !win_valid_q || io.win_ready;
   assign io.win_valid = win_valid_q;
   assign io.win_last  = win_last_q;
   assign io.window    = window_q;

   assign accept   = io.pix_valid && io.pix_ready;
   assign last_col = (col == CW'(IMG_W - 1));
   assign last_row = (row == RW'(IMG_H - 1));
   // Positions with row or col below 2 would mix in stale row-end or previous-frame pixels.
   assign produce  = accept && (row >= RW'(2)) && (col >= CW'(2));

   line_buffer #(.DATA_W(DATA_W), .DEPTH(IMG_W)) u_row1 (
      .clk  (clk),
      .rst  (rst),
      .en   (accept),
      .din  (io.pix_data),
      .dout (row1_pix)
   );

   line_buffer #(.DATA_W(DATA_W), .DEPTH(IMG_W)) u_row2 (
      .clk  (clk),
      .rst  (rst),
      .en   (accept),
      .din  (row1_pix),
      .dout (row2_pix)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         col <= '0;
         row <= '0;
      end else if (accept) begin
         col <= last_col ? '0 : col + 1'b1;
         if (last_col) begin
            row <= last_row ? '0 : row + 1'b1;
         end
      end
   end

   always_comb begin
      for (int r = 0; r < KERNEL; r++) begin
         for (int c = 0; c < KERNEL - 1; c++) begin
            next_arr[r][c] = arr[r][c+1];
         end
      end
      next_arr[0][KERNEL-1] = row2_pix;
      next_arr[1][KERNEL-1] = row1_pix;
      next_arr[2][KERNEL-1] = io.pix_data;
   end

   always_comb begin
      next_win = '0;
      for (int r = 0; r < KERNEL; r++) begin
         for (int c = 0; c < KERNEL; c++) begin
            next_win[win_lsb(r, c, DATA_W) +: DATA_W] = next_arr[r][c];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int r = 0; r < KERNEL; r++) begin
            for (int c = 0; c < KERNEL; c++) begin
               arr[r][c] <= '0;
            end
         end
      end else if (accept) begin
         arr <= next_arr;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         win_valid_q <= 1'b0;
         win_last_q  <= 1'b0;
         window_q    <= '0;
      end else if (produce) begin
         win_valid_q <= 1'b1;
         win_last_q  <= last_col && last_row;
         window_q    <= next_win;
      end else if (io.win_ready) begin
         win_valid_q <= 1'b0;
      end
   end

endmodule

// File: doc/conv_window_gen.md
# conv_window_gen

Streaming 3x3 window generator that feeds the convolution datapath. It accepts a raster-order pixel stream with a valid/ready handshake and buffers the two previous image rows. For every pixel position that completes a full 3x3 neighbourhood, it emits one packed 72-bit window. The window is laid out exactly as `mult_add` expects on its `in` port, so `window` connects directly to `mult_add.in`, and the window's result is read from `convValue`. Only valid (no-padding) windows are produced.

## Interface
- `DATA_W`, default 8: pixel width (signed, passed through untouched).
- `IMG_W`, default 28: image columns, at least 3.
- `IMG_H`, default 28: image rows, at least 3.

Ports:
- `clk`, input, 1: sole clock.
- `rst`, input, 1: reset, asynchronous, active-high.
- `pix_valid`, input, 1: input pixel valid.
- `pix_ready`, output, 1: block can accept a pixel.
- `pix_data`, input, `DATA_W`: pixel in raster order, row 0 first.
- `win_valid`, output, 1: `window` holds a valid 3x3 window.
- `win_ready`, input, 1: downstream accepts the window.
- `window`, output, `9*DATA_W`: packed window. Element (r,c) sits at bits `[DATA_W*(8-(3r+c)) +: DATA_W]`. r=0 is the oldest row and c=0 the leftmost column, so top-left is in the MSBs and bottom-right in the LSBs.
- `win_last`, output, 1: qualifies the last window of a frame.

## Operation
- A pixel is accepted when `pix_valid && pix_ready`; nothing else changes state.
- The column counter runs 0..`IMG_W`-1 and the row counter 0..`IMG_H`-1, both advancing on acceptance.
  - After (`IMG_H`-1, `IMG_W`-1), both wrap to 0 and the next frame starts immediately.
- Two line buffers, each `IMG_W` deep, delay the stream by one row and two rows.
  - On acceptance, the current pixel, the 1-row-delayed pixel and the 2-row-delayed pixel shift into the right column of a 3x3 register array.
- A window is produced for an accepted pixel at (row, col) iff row ≥ 2 and col ≥ 2.
  - Stale data from the previous row end or frame is never emitted, because such positions fail this test.
- Windows per frame: (`IMG_H`-2)×(`IMG_W`-2), in raster order.
- `win_last` = 1 with the window produced by pixel (`IMG_H`-1, `IMG_W`-1); otherwise 0.
- There is no arithmetic: data bits pass through unchanged and signedness is irrelevant.

Output handshake (single output register):
- `pix_ready` = !`win_valid` || `win_ready`, combinational.
- While `win_valid` && !`win_ready`:
  - `window` and `win_last` stay stable.
  - No pixel is accepted, counters hold, and line buffers hold.
- If a window is accepted and no new window is produced in that cycle, `win_valid` falls on the next cycle.
- A window accepted in the same cycle a new one is produced is replaced back-to-back with no bubble.

## Timing
- Latency: the window for pixel (r,c) is on `window` with `win_valid` = 1 in the cycle after that pixel is accepted.
- Throughput: one pixel and one window per cycle when `win_ready` is held high.
- Reset values:
  - `win_valid` = 0, `win_last` = 0, `window` = 0.
  - Row and column counters = 0, and the 3x3 array = 0.
  - `pix_ready` = 1 after reset, because it is derived.
  - Line buffer contents are not reset; they are masked by the row/col rule.
- Reset mid-frame:
  - Any pending window is dropped.
  - The next accepted pixel is treated as (0,0) of a new frame.
- A gap with `pix_valid` low mid-row changes nothing; the neighbourhood stays contiguous.

## Structure
- Shared package `conv_pkg` holds:
  - `KERNEL` = 3 and `DATA_W` = 8.
  - `WIN_W` = `KERNEL*KERNEL*DATA_W`.
  - The index function for element (r,c) into the packed vector, reused by `mult_add` benches.
- Sub-module `line_buffer` (parameters `DATA_W`, `DEPTH`):
  - Enable-gated delay line (shift register or circular RAM with one pointer).
  - Instantiated twice, chained.
- Top level holds the counters, the 3x3 array and the output register.

## Test plan
Use `IMG_W`=5, `IMG_H`=4, pixel(r,c) = 5r+c+1 (values 1..20), and connect `window` to `mult_add` with all weights = 1.

1. **Basic stream.** Stream all 20 pixels with `win_ready`=1 → exactly 6 windows. The first follows acceptance of pixel 13 and is {1,2,3,6,7,8,11,12,13} (MSB→LSB), with `convValue` = 63.
2. **Last window.** Same stream → the final window is {8,9,10,13,14,15,18,19,20} with `win_last`=1, and `win_last`=0 on the other five.
3. **Row-start suppression.** Same stream → no `win_valid` after pixels 11, 12, 16 or 17 (col < 2). A window follows pixel 18, and that window is {6,7,8,11,12,13,16,17,18}.
4. **Backpressure.** Hold `win_ready`=0 for 3 cycles while the first window is valid → `pix_ready`=0 and `window` is stable. Then raise `win_ready` → the stream resumes and the later windows are unchanged.
5. **Back-to-back frames.** Send two back-to-back frames with no gap → 12 windows total. The second frame's first window is again {1,2,3,6,7,8,11,12,13}.
6. **Reset mid-frame.** Assert `rst` asynchronously after pixel 14 → `win_valid`=0 and `window`=0 immediately. Restart from pixel 1 → the first window again follows pixel 13.
